// File: rtl/adjust_pkg.sv
// Shared state encoding and default timing constants for the time-setting controller.
package adjust_pkg;

  typedef enum logic {
    NORM = 1'b0,
    ADJ  = 1'b1
  } state_t;

  localparam int RPT_DLY_DEF = 50;
  localparam int RPT_PER_DEF = 10;
  localparam int TOUT_S_DEF  = 30;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/adjust_ctrl_auto_repeat.sv
// ADJUST edge detect plus hold-to-repeat pulse generation.
module auto_repeat
  import adjust_pkg::*;
#(
  parameter int RPT_DLY = RPT_DLY_DEF,
  parameter int RPT_PER = RPT_PER_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic ENABLE,
  input  logic KEY,
  input  logic TICK,
  input  logic RPT_EN,
  output logic PULSE
);

  localparam int CW = $clog2(max2(RPT_DLY, RPT_PER) + 1);
  localparam logic [CW-1:0] DLY_LD = CW'(RPT_DLY);
  localparam logic [CW-1:0] PER_LD = CW'(RPT_PER);

  logic          key_q, key_d;
  logic          arm_q, arm_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          edge_det;

  // Down-counter reloads with the delay on the edge, then with the period on every hit.
  always_comb begin
    key_d    = KEY;
    arm_d    = arm_q;
    cnt_d    = cnt_q;
    PULSE    = 1'b0;
    edge_det = KEY & ~key_q;
    if (!ENABLE || !KEY) begin
      arm_d = 1'b0;
      cnt_d = '0;
    end else if (edge_det) begin
      PULSE = 1'b1;
      arm_d = RPT_EN;
      cnt_d = RPT_EN ? DLY_LD : '0;
    end else if (arm_q && TICK) begin
      if (cnt_q == CW'(1)) begin
        PULSE = 1'b1;
        cnt_d = PER_LD;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      key_q <= 1'b0;
      arm_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      key_q <= key_d;
      arm_q <= arm_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/adjust_ctrl.sv
// Time-setting controller: field select, clear/increment pulses, inactivity timeout, blink.
// state | meaning
// NORM  | clock running, ADJUST ignored, all fields lit
// ADJ   | adjusting field FIELD, selected field blinks unless ADJUST held
module adjust_ctrl
  import adjust_pkg::*;
#(
  parameter int                NFIELD  = 3,
  parameter logic [NFIELD-1:0] CLRMASK = NFIELD'(1),
  parameter int                RPT_DLY = RPT_DLY_DEF,
  parameter int                RPT_PER = RPT_PER_DEF,
  parameter int                TOUT_S  = TOUT_S_DEF
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      EN100HZ,
  input  logic                      EN1HZ,
  input  logic                      SIG2HZ,
  input  logic                      MODE,
  input  logic                      SELECT,
  input  logic                      ADJUST,
  output logic [NFIELD-1:0]         CLR,
  output logic [NFIELD-1:0]         INC,
  output logic [NFIELD-1:0]         ON,
  output logic                      ADJMODE,
  output logic [$clog2(NFIELD)-1:0] FIELD
);

  localparam int FW = $clog2(NFIELD);
  localparam int TW = (TOUT_S > 0) ? $clog2(TOUT_S + 1) : 1;

  state_t            state_q, state_d;
  logic [FW-1:0]     field_q, field_d;
  logic [TW-1:0]     tout_q, tout_d;
  logic [NFIELD-1:0] clr_q, clr_d, inc_q, inc_d;
  logic              timeout, rpt_enable, pulse;

  assign timeout    = (TOUT_S != 0) && (tout_q == TW'(TOUT_S));
  assign rpt_enable = (state_q == ADJ) && !MODE && !SELECT && !timeout;

  auto_repeat #(
    .RPT_DLY(RPT_DLY),
    .RPT_PER(RPT_PER)
  ) u_auto_repeat (
    .CLK   (CLK),
    .RST   (RST),
    .ENABLE(rpt_enable),
    .KEY   (ADJUST),
    .TICK  (EN100HZ),
    .RPT_EN(~CLRMASK[field_q]),
    .PULSE (pulse)
  );

  always_comb begin
    state_d = state_q;
    field_d = field_q;
    tout_d  = tout_q;
    clr_d   = '0;
    inc_d   = '0;
    case (state_q)
      NORM: begin
        if (MODE) begin
          state_d = ADJ;
          field_d = '0;
          tout_d  = '0;
        end
      end
      ADJ: begin
        if (MODE || timeout) begin
          state_d = NORM;
          tout_d  = '0;
        end else if (SELECT) begin
          field_d = (field_q == '0) ? FW'(NFIELD - 1) : field_q - FW'(1);
          tout_d  = '0;
        end else if (ADJUST) begin
          tout_d = '0;
        end else if (EN1HZ && tout_q != TW'(TOUT_S)) begin
          tout_d = tout_q + TW'(1);
        end
      end
      default: state_d = NORM;
    endcase
    if (pulse) begin
      if (CLRMASK[field_q]) clr_d[field_q] = 1'b1;
      else                  inc_d[field_q] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= NORM;
      field_q <= '0;
      tout_q  <= '0;
      clr_q   <= '0;
      inc_q   <= '0;
    end else begin
      state_q <= state_d;
      field_q <= field_d;
      tout_q  <= tout_d;
      clr_q   <= clr_d;
      inc_q   <= inc_d;
    end
  end

  // Masking with RST keeps a pulse registered just before reset off the outputs.
  assign CLR     = clr_q & {NFIELD{~RST}};
  assign INC     = inc_q & {NFIELD{~RST}};
  assign ADJMODE = (state_q == ADJ);
  assign FIELD   = field_q;

  always_comb begin
    ON = '1;
    if (ADJMODE && SIG2HZ && !ADJUST) ON[field_q] = 1'b0;
  end

endmodule

// File: tb/tb_adjust_ctrl.sv
// Directed bench for adjust_ctrl: pulses are checked by a scoreboard monitor, levels directly.
module tb_adjust_ctrl;

  logic       CLK = 1'b0;
  logic       RST, EN100HZ, EN1HZ, SIG2HZ, MODE, SELECT, ADJUST;
  logic [2:0] CLR, INC, ON;
  logic       ADJMODE;
  logic [1:0] FIELD;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int         c;
    logic [2:0] clr;
    logic [2:0] inc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  adjust_ctrl dut (
    .CLK    (CLK),
    .RST    (RST),
    .EN100HZ(EN100HZ),
    .EN1HZ  (EN1HZ),
    .SIG2HZ (SIG2HZ),
    .MODE   (MODE),
    .SELECT (SELECT),
    .ADJUST (ADJUST),
    .CLR    (CLR),
    .INC    (INC),
    .ON     (ON),
    .ADJMODE(ADJMODE),
    .FIELD  (FIELD)
  );

  // Any nonzero CLR/INC must match the oldest expected pulse, including its cycle.
  always @(negedge CLK) begin
    if ((CLR | INC) !== 3'b000) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_pulse: cyc %0d CLR=%b INC=%b, required no pulse", cyc, CLR, INC);
      end else begin
        mon_e = exp_q.pop_front();
        if (cyc !== mon_e.c || CLR !== mon_e.clr || INC !== mon_e.inc) begin
          miscompares++;
          $display("FAIL pulse: got cyc %0d CLR=%b INC=%b, expected cyc %0d CLR=%b INC=%b",
                   cyc, CLR, INC, mon_e.c, mon_e.clr, mon_e.inc);
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_pulse(input int c, input logic [2:0] clr, input logic [2:0] inc);
    exp_t e;
    e.c = c;
    e.clr = clr;
    e.inc = inc;
    exp_q.push_back(e);
  endtask

  task automatic pulse_mode();
    MODE = 1'b1;
    step();
    MODE = 1'b0;
  endtask

  task automatic pulse_sel();
    SELECT = 1'b1;
    step();
    SELECT = 1'b0;
  endtask

  task automatic tick_fast();
    EN100HZ = 1'b1;
    step();
    EN100HZ = 1'b0;
    repeat (3) step();
  endtask

  task automatic tick_slow();
    EN1HZ = 1'b1;
    step();
    EN1HZ = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    RST = 1'b1; EN100HZ = 1'b0; EN1HZ = 1'b0; SIG2HZ = 1'b0;
    MODE = 1'b0; SELECT = 1'b0; ADJUST = 1'b0;
    step(); step();
    RST = 1'b0;
    step();
    check("reset_adjmode", ADJMODE, 0);
    check("reset_field", FIELD, 0);
    check("reset_on", ON, 3'b111);
    check("reset_clr", CLR, 0);
    check("reset_inc", INC, 0);

    // mode entry and field walk
    pulse_mode();
    check("enter_adjmode", ADJMODE, 1);
    check("enter_field", FIELD, 0);
    pulse_sel(); check("sel1_field", FIELD, 2);
    pulse_sel(); check("sel2_field", FIELD, 1);
    pulse_sel(); check("sel3_field", FIELD, 0);
    pulse_mode();
    check("exit_adjmode", ADJMODE, 0);
    check("exit_on", ON, 3'b111);

    // clear field: single pulse, no repeat
    pulse_mode();
    ADJUST = 1'b1;
    expect_pulse(cyc + 1, 3'b001, 3'b000);
    step();
    for (int t = 1; t <= 200; t++) tick_fast();
    ADJUST = 1'b0;
    step();

    // increment field with auto-repeat: edge, then ticks 50,60,...,100
    pulse_sel(); pulse_sel();
    check("inc_field", FIELD, 1);
    ADJUST = 1'b1;
    expect_pulse(cyc + 1, 3'b000, 3'b010);
    step();
    for (int t = 1; t <= 100; t++) begin
      if (t >= 50 && (t - 50) % 10 == 0) expect_pulse(cyc + 1, 3'b000, 3'b010);
      tick_fast();
    end
    ADJUST = 1'b0;
    step();
    for (int t = 1; t <= 20; t++) tick_fast();
    check("after_release_adjmode", ADJMODE, 1);

    // timeout after 30 idle seconds
    pulse_mode(); pulse_mode();
    for (int i = 1; i <= 30; i++) begin
      tick_slow();
      check("timeout_a", ADJMODE, (i < 30));
    end

    // ADJUST press at second 20 restarts the timeout
    pulse_mode();
    for (int i = 1; i <= 20; i++) tick_slow();
    ADJUST = 1'b1;
    expect_pulse(cyc + 1, 3'b001, 3'b000);
    step();
    ADJUST = 1'b0;
    step();
    for (int i = 21; i <= 50; i++) begin
      tick_slow();
      check("timeout_b", ADJMODE, (i < 50));
    end

    // blink on field 2
    pulse_mode();
    pulse_sel();
    check("blink_field", FIELD, 2);
    SIG2HZ = 1'b1; step(); check("blink_on_hi", ON, 3'b011);
    SIG2HZ = 1'b0; step(); check("blink_on_lo", ON, 3'b111);
    ADJUST = 1'b1;
    expect_pulse(cyc + 1, 3'b000, 3'b100);
    SIG2HZ = 1'b1; step(); check("blink_held_hi", ON, 3'b111);
    SIG2HZ = 1'b0; step(); check("blink_held_lo", ON, 3'b111);
    ADJUST = 1'b0;
    SIG2HZ = 1'b1; step(); check("blink_rel_hi", ON, 3'b011);
    SIG2HZ = 1'b0;

    // MODE beats SELECT; FIELD held in NORM
    MODE = 1'b1; SELECT = 1'b1;
    step();
    MODE = 1'b0; SELECT = 1'b0;
    check("mode_sel_adjmode", ADJMODE, 0);
    check("mode_sel_field", FIELD, 2);
    SIG2HZ = 1'b1; step(); check("norm_on", ON, 3'b111);
    SIG2HZ = 1'b0;

    // SELECT beats an ADJUST edge: field moves, no pulse
    pulse_mode();
    check("reentry_field", FIELD, 0);
    SELECT = 1'b1; ADJUST = 1'b1;
    step();
    SELECT = 1'b0;
    check("sel_adj_field", FIELD, 2);
    step(); step();
    ADJUST = 1'b0;
    step();

    // reset in the middle of a repeat sequence
    ADJUST = 1'b1;
    expect_pulse(cyc + 1, 3'b000, 3'b100);
    step();
    for (int t = 1; t <= 49; t++) tick_fast();
    EN100HZ = 1'b1; RST = 1'b1;
    step();
    EN100HZ = 1'b0;
    check("rst_adjmode", ADJMODE, 0);
    check("rst_field", FIELD, 0);
    RST = 1'b0;
    step();
    check("rst_next_clr", CLR, 0);
    check("rst_next_inc", INC, 0);
    for (int t = 1; t <= 15; t++) tick_fast();
    ADJUST = 1'b0;
    repeat (3) step();

    check("pending_pulses", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/adjust_ctrl.md
Name: adjust_ctrl

Overview:
- Parametrised time-setting controller for the clock designs; successor to the fixed 3-field SEC/MIN/HOUR adjust FSM.
- Supports NFIELD adjustable fields, with a per-field clear-vs-increment selection.
- Adds auto-repeat on a held ADJUST, an inactivity timeout back to normal mode, and blink suppression while a field is being adjusted.
- Sits between the debounced button block and the time counters; drives their CLR/INC inputs and the display blanking.

Parameters:
- NFIELD, 3: number of adjustable fields. Field 0 is the least significant (seconds). Legal range 2..8.
- CLRMASK, 3'b001: bit i=1 means field i is cleared on adjust (no repeat); bit i=0 means field i is incremented (auto-repeat). Width NFIELD.
- RPT_DLY, 50: EN100HZ ticks ADJUST must be held before auto-repeat starts (0.5 s). Legal range ≥ 1.
- RPT_PER, 10: EN100HZ ticks between repeat pulses (10 Hz). Legal range ≥ 1.
- TOUT_S, 30: EN1HZ ticks of inactivity before returning to normal mode. 0 disables the timeout.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous active-high reset.
- EN100HZ  in  1  one-CLK enable pulse at 100 Hz.
- EN1HZ  in  1  one-CLK enable pulse at 1 Hz.
- SIG2HZ  in  1  2 Hz, 50% blink square wave.
- MODE  in  1  one-CLK pulse, debounced and edge-detected upstream.
- SELECT  in  1  one-CLK pulse, debounced and edge-detected upstream.
- ADJUST  in  1  debounced level, high while the button is held.
- CLR  out  NFIELD  one-hot one-CLK clear pulse to field i.
- INC  out  NFIELD  one-hot one-CLK increment pulse to field i.
- ON  out  NFIELD  display enable per field; 0 blanks the field.
- ADJMODE  out  1  high while in adjust mode.
- FIELD  out  $clog2(NFIELD)  index of the currently selected field.

Behaviour:
- One clock; reset is synchronous and active-high.
- On reset: state NORM, FIELD=0, CLR=0, INC=0, ON=all 1s, ADJMODE=0, all counters 0, ADJUST edge register 0.
- Applying RST mid-repeat or mid-adjust aborts at once; no pulse is emitted in the reset cycle or the following cycle.

State machine:
- Two states, NORM and ADJ, plus a FIELD index register.
- NORM → ADJ on MODE. FIELD is set to 0 on entry.
- ADJ → NORM on MODE, or on timeout. FIELD is held, but is set to 0 on the next entry.
- In ADJ, SELECT sets FIELD to FIELD-1. It wraps from 0 to NFIELD-1 (with 3 fields: 0→2→1→0).
- Priority within a cycle: MODE > SELECT > ADJUST. If SELECT and an ADJUST rising edge arrive in the same cycle, FIELD moves and no pulse is emitted.

Adjust pulses (ADJ only; ADJUST is ignored in NORM):
- Registered outputs. The pulse appears on CLR/INC exactly one CLK after the cycle in which ADJUST is first sampled high (rising edge detected internally).
- Rising edge: one pulse on CLR[FIELD] if CLRMASK[FIELD]=1, otherwise on INC[FIELD].
- Increment fields, ADJUST still held:
  - After RPT_DLY EN100HZ ticks counted from the edge, emit one INC pulse.
  - Then emit one INC pulse every RPT_PER EN100HZ ticks.
  - Stop on ADJUST low, SELECT, MODE or timeout; the repeat counter clears.
- Clear fields never repeat.
- At most one bit of CLR|INC is high in any cycle.

Timeout:
- The counter counts EN1HZ ticks in ADJ while ADJUST is low.
- It clears on MODE, SELECT, ADJUST high, and on entry to ADJ.
- When the count reaches TOUT_S: go to NORM on the next CLK with no pulse emitted.
- TOUT_S=0: the counter never fires.

Blink:
- ON[i] = 0 only when ADJMODE=1, FIELD==i, SIG2HZ=1 and ADJUST=0.
- While ADJUST is held the selected field stays lit.
- All ON bits are 1 in NORM.

ADJMODE: high exactly while the state is ADJ.

Widths:
- Repeat counter is $clog2(max(RPT_DLY,RPT_PER)+1) bits.
- Timeout counter is $clog2(TOUT_S+1) bits.
- Counters saturate; they never wrap.

Decomposition:
- Package adjust_pkg holds the state encoding constants NORM/ADJ and the default values of RPT_DLY, RPT_PER and TOUT_S.
- One sub-module, auto_repeat, holds the edge detect, delay/period counter and pulse generation. It takes ENABLE, KEY, TICK and RPT_EN, and outputs PULSE.
- The FSM, FIELD register, timeout, decode and blink logic stay in adjust_ctrl.

Test Plan:
- RST, then MODE → ADJMODE=1, FIELD=0. SELECT×3 → FIELD 2,1,0. MODE → ADJMODE=0, ON=3'b111.
- FIELD=0, ADJUST held 200 EN100HZ ticks → exactly one CLR[0] pulse, one CLK after the edge; INC stays 0.
- FIELD=1, ADJUST held 100 ticks with defaults → INC[1] pulses at edge+1 CLK, then at ticks 50, 60, 70, 80, 90, 100: 7 pulses total. Release → no further pulses.
- ADJ with no activity, defaults → ADJMODE falls after the 30th EN1HZ. Repeat with an ADJUST press at EN1HZ #20 → timeout restarts and exits at #50.
- SIG2HZ toggling, FIELD=2, ADJ → ON=3'b011 while SIG2HZ=1, 3'b111 otherwise. With ADJUST held → ON=3'b111 throughout.
- Same-cycle MODE+SELECT in ADJ → NORM, FIELD unchanged. Same-cycle SELECT+ADJUST edge → FIELD decremented, no pulse. RST during repeat → CLR=INC=0 the next cycle.
